// File: rtl/display_pkg.sv
// Shared display constants: state encoding and the 595 register width.
// Also used by the clock core's digit/segment encoder.
package display_pkg;

  localparam int unsigned BYTE_W  = 8;
  localparam int unsigned STATE_W = 2;

  localparam logic [STATE_W-1:0] S_IDLE     = 2'd0;
  localparam logic [STATE_W-1:0] S_SHIFT_LO = 2'd1;
  localparam logic [STATE_W-1:0] S_SHIFT_HI = 2'd2;
  localparam logic [STATE_W-1:0] S_LATCH    = 2'd3;

  typedef enum logic [STATE_W-1:0] {
    IDLE     = S_IDLE,
    SHIFT_LO = S_SHIFT_LO,
    SHIFT_HI = S_SHIFT_HI,
    LATCH    = S_LATCH
  } state_t;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/phase_timer.sv
// Loadable down-counter with a zero flag; times the clk_out half-periods and the latch pulse.
module phase_timer #(
  parameter int unsigned W = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero_c
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Stops at zero, so a missed reload can never wrap into a long interval.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_c = (cnt_q == '0);

endmodule

// File: rtl/serial_display_driver.sv
// Streams a frame into a cascaded 74HC595 chain and strobes the storage latch,
// with a one-deep pending buffer so the next frame can be posted while one is shifting.
module serial_display_driver #(
  parameter  int unsigned N_BYTES      = 4,
  parameter  int unsigned CLK_DIV      = 2,
  parameter  int unsigned LATCH_CYCLES = 2,
  parameter  int unsigned MSB_FIRST    = 1,
  localparam int unsigned NBITS        = display_pkg::BYTE_W * N_BYTES
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NBITS-1:0] data_in,
  input  logic             load,
  output logic             busy,
  output logic             pending,
  output logic             done,
  output logic             serial_out,
  output logic             clk_out,
  output logic             latch_out
);

  import display_pkg::*;

  localparam int unsigned BITCNT_W = $clog2(NBITS);
  localparam int unsigned TMR_W    = $clog2(max_u(CLK_DIV, LATCH_CYCLES) + 1);

  localparam logic [BITCNT_W-1:0] LAST_BIT   = BITCNT_W'(NBITS - 1);
  localparam logic [TMR_W-1:0]    DIV_LOAD   = TMR_W'(CLK_DIV - 1);
  localparam logic [TMR_W-1:0]    LATCH_LOAD = TMR_W'(LATCH_CYCLES - 1);

  state_t              state_q,     state_d;
  logic [NBITS-1:0]    shift_q,     shift_d;
  logic [NBITS-1:0]    pend_buf_q,  pend_buf_d;
  logic                pending_q,   pending_d;
  logic [BITCNT_W-1:0] bitcnt_q,    bitcnt_d;
  logic                busy_q,      busy_d;
  logic                done_q,      done_d;
  logic                serial_out_q, serial_out_d;
  logic                clk_out_q,   clk_out_d;
  logic                latch_out_q, latch_out_d;

  logic                tmr_load_c;
  logic [TMR_W-1:0]    tmr_val_c;
  logic                tmr_zero_c;
  logic [NBITS-1:0]    shifted_c;
  logic [NBITS-1:0]    next_frame_c;

  function automatic logic first_bit(input logic [NBITS-1:0] v);
    return (MSB_FIRST != 0) ? v[NBITS-1] : v[0];
  endfunction

  function automatic logic [NBITS-1:0] shift_once(input logic [NBITS-1:0] v);
    if (MSB_FIRST != 0) begin
      return {v[NBITS-2:0], 1'b0};
    end
    return {1'b0, v[NBITS-1:1]};
  endfunction

  phase_timer #(
    .W (TMR_W)
  ) u_phase_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_load_c),
    .load_val (tmr_val_c),
    .zero_c   (tmr_zero_c)
  );

  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    pend_buf_d   = pend_buf_q;
    pending_d    = pending_q;
    bitcnt_d     = bitcnt_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    serial_out_d = serial_out_q;
    clk_out_d    = clk_out_q;
    latch_out_d  = latch_out_q;
    tmr_load_c   = 1'b0;
    tmr_val_c    = DIV_LOAD;
    shifted_c    = shift_once(shift_q);
    // A load in the final latch cycle must win over an older posted frame.
    next_frame_c = load ? data_in : pend_buf_q;

    if (load && (state_q != IDLE)) begin
      pend_buf_d = data_in;
      pending_d  = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (load) begin
          shift_d      = data_in;
          serial_out_d = first_bit(data_in);
          bitcnt_d     = '0;
          busy_d       = 1'b1;
          clk_out_d    = 1'b0;
          tmr_load_c   = 1'b1;
          state_d      = SHIFT_LO;
        end
      end
      SHIFT_LO: begin
        if (tmr_zero_c) begin
          clk_out_d  = 1'b1;
          tmr_load_c = 1'b1;
          state_d    = SHIFT_HI;
        end
      end
      SHIFT_HI: begin
        if (tmr_zero_c) begin
          clk_out_d  = 1'b0;
          tmr_load_c = 1'b1;
          if (bitcnt_q == LAST_BIT) begin
            serial_out_d = 1'b0;
            latch_out_d  = 1'b1;
            tmr_val_c    = LATCH_LOAD;
            state_d      = LATCH;
          end else begin
            shift_d      = shifted_c;
            serial_out_d = first_bit(shifted_c);
            bitcnt_d     = bitcnt_q + BITCNT_W'(1);
            state_d      = SHIFT_LO;
          end
        end
      end
      LATCH: begin
        if (tmr_zero_c) begin
          latch_out_d = 1'b0;
          done_d      = 1'b1;
          if (pending_q || load) begin
            shift_d      = next_frame_c;
            serial_out_d = first_bit(next_frame_c);
            bitcnt_d     = '0;
            pending_d    = 1'b0;
            tmr_load_c   = 1'b1;
            state_d      = SHIFT_LO;
          end else begin
            busy_d  = 1'b0;
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      shift_q      <= '0;
      pend_buf_q   <= '0;
      pending_q    <= 1'b0;
      bitcnt_q     <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      serial_out_q <= 1'b0;
      clk_out_q    <= 1'b0;
      latch_out_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      pend_buf_q   <= pend_buf_d;
      pending_q    <= pending_d;
      bitcnt_q     <= bitcnt_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      serial_out_q <= serial_out_d;
      clk_out_q    <= clk_out_d;
      latch_out_q  <= latch_out_d;
    end
  end

  assign busy       = busy_q;
  assign pending    = pending_q;
  assign done       = done_q;
  assign serial_out = serial_out_q;
  assign clk_out    = clk_out_q;
  assign latch_out  = latch_out_q;

endmodule
